// File: rtl/hazard_sequencer.sv
// Purpose : pipeline control sequencer - load-use stalls, branch squash, halt drain, stall counter.
// Latency : control outputs are combinational from registered state plus current inputs (same cycle).
// Backpressure: hold_p1 freezes PC and p1->p2; kill_p2/kill_p3 inject NOPs; no handshake of its own.
//
// Ports:
//   clock, reset                      single clock, synchronous active-high reset
//   read_addr_from_p2_A/B, use_A/B_p2 sources read by the instruction in p2
//   write_addr_from_p3/p4, load_p3/p4 destinations and load flags of p3 / p4
//   branch_taken_p3, halt_p2, resume  branch resolution, HALT in p2, leave halted state
//   hold_p1, kill_p2, kill_p3         pipeline register hold / NOP-insert controls
//   pc_redirect, halted               PC loads branch target; pipeline halted
//   stall_cycles                      saturating count of load-use stall cycles
module hazard_sequencer #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  read_addr_from_p2_A,
    input  logic [2:0]  read_addr_from_p2_B,
    input  logic        use_A_p2,
    input  logic        use_B_p2,
    input  logic [2:0]  write_addr_from_p3,
    input  logic [2:0]  write_addr_from_p4,
    input  logic        load_p3,
    input  logic        load_p4,
    input  logic        branch_taken_p3,
    input  logic        halt_p2,
    input  logic        resume,
    output logic        hold_p1,
    output logic        kill_p2,
    output logic        kill_p3,
    output logic        pc_redirect,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        DRAIN      = 2'd2,
        HALTED     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  dcnt_q, dcnt_d;
    logic [15:0] cnt_q;
    logic        stall_inc;
    logic        hz3, hz4;

    // Load data only exists from p5, so a consumer in p2 behind a load in
    // p3 needs two bubbles and behind a load in p4 needs one. No r0 exemption.
    assign hz3 = load_p3 & ((use_A_p2 & (read_addr_from_p2_A == write_addr_from_p3)) |
                            (use_B_p2 & (read_addr_from_p2_B == write_addr_from_p3)));
    assign hz4 = load_p4 & ((use_A_p2 & (read_addr_from_p2_A == write_addr_from_p4)) |
                            (use_B_p2 & (read_addr_from_p2_B == write_addr_from_p4)));

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        stall_inc   = 1'b0;
        hold_p1     = 1'b0;
        kill_p2     = 1'b0;
        kill_p3     = 1'b0;
        pc_redirect = 1'b0;
        halted      = 1'b0;

        case (state_q)
            RUN: begin
                if (branch_taken_p3) begin
                    kill_p2     = 1'b1;
                    kill_p3     = 1'b1;
                    pc_redirect = 1'b1;
                end else if (hz3) begin
                    hold_p1   = 1'b1;
                    kill_p3   = 1'b1;
                    stall_inc = 1'b1;
                    state_d   = LOAD_STALL;
                end else if (hz4) begin
                    hold_p1   = 1'b1;
                    kill_p3   = 1'b1;
                    stall_inc = 1'b1;
                end else if (halt_p2) begin
                    // HALT itself moves on to p3; everything behind it is frozen.
                    hold_p1 = 1'b1;
                    kill_p2 = 1'b1;
                    dcnt_d  = 2'(DRAIN_CYCLES - 1);
                    state_d = DRAIN;
                end
            end
            LOAD_STALL: begin
                // Second bubble of a p3 load-use; a taken branch squashes the
                // consumer anyway, so it wins and no stall is charged.
                if (branch_taken_p3) begin
                    kill_p2     = 1'b1;
                    kill_p3     = 1'b1;
                    pc_redirect = 1'b1;
                end else begin
                    hold_p1   = 1'b1;
                    kill_p3   = 1'b1;
                    stall_inc = 1'b1;
                end
                state_d = RUN;
            end
            DRAIN: begin
                hold_p1 = 1'b1;
                kill_p2 = 1'b1;
                kill_p3 = 1'b1;
                if (dcnt_q == 2'd0) begin
                    state_d = HALTED;
                end else begin
                    dcnt_d = dcnt_q - 2'd1;
                end
            end
            HALTED: begin
                halted  = 1'b1;
                hold_p1 = 1'b1;
                kill_p2 = 1'b1;
                kill_p3 = 1'b1;
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        // Reset forces every control low in the cycle it is asserted.
        if (reset) begin
            hold_p1     = 1'b0;
            kill_p2     = 1'b0;
            kill_p3     = 1'b0;
            pc_redirect = 1'b0;
            halted      = 1'b0;
            stall_inc   = 1'b0;
        end
    end

    assign stall_cycles = reset ? 16'd0 : cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            dcnt_q  <= 2'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            if (stall_inc && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

    localparam int DRAIN = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  a_addr, b_addr, w3, w4;
    logic        use_a, use_b, ld3, ld4, br, hlt, res;
    logic        hold_p1, kill_p2, kill_p3, pc_redirect, halted;
    logic [15:0] stall_cycles;

    always #5 clock = ~clock;

    hazard_sequencer #(.DRAIN_CYCLES(DRAIN)) dut (
        .clock(clock), .reset(reset),
        .read_addr_from_p2_A(a_addr), .read_addr_from_p2_B(b_addr),
        .use_A_p2(use_a), .use_B_p2(use_b),
        .write_addr_from_p3(w3), .write_addr_from_p4(w4),
        .load_p3(ld3), .load_p4(ld4),
        .branch_taken_p3(br), .halt_p2(hlt), .resume(res),
        .hold_p1(hold_p1), .kill_p2(kill_p2), .kill_p3(kill_p3),
        .pc_redirect(pc_redirect), .halted(halted), .stall_cycles(stall_cycles)
    );

    typedef struct packed {
        logic        rst;
        logic [2:0]  a, b, w3, w4;
        logic        ua, ub, l3, l4, br, hlt, res;
    } stim_t;

    typedef struct packed {
        logic        hold, k2, k3, redir, halted;
        logic [15:0] cnt;
    } resp_t;

    resp_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;

    // Reference model: remaining bubbles / remaining drain cycles as plain counts.
    int    bubbles_left = 0;
    int    drain_left   = 0;
    bit    is_halted    = 0;
    int    stall_total  = 0;

    function automatic resp_t model(input stim_t s);
        resp_t r;
        bit    dep3, dep4;
        r = '0;
        dep3 = s.l3 && ((s.ua && s.a == s.w3) || (s.ub && s.b == s.w3));
        dep4 = s.l4 && ((s.ua && s.a == s.w4) || (s.ub && s.b == s.w4));
        if (s.rst) begin
            bubbles_left = 0; drain_left = 0; is_halted = 0; stall_total = 0;
            return r;
        end
        r.cnt = (stall_total > 65535) ? 16'hFFFF : 16'(stall_total);
        if (is_halted) begin
            r.halted = 1; r.hold = 1; r.k2 = 1; r.k3 = 1;
            if (s.res) is_halted = 0;
        end else if (drain_left > 0) begin
            r.hold = 1; r.k2 = 1; r.k3 = 1;
            drain_left--;
            if (drain_left == 0) is_halted = 1;
        end else if (s.br) begin
            r.k2 = 1; r.k3 = 1; r.redir = 1;
            bubbles_left = 0;
        end else if (bubbles_left > 0) begin
            r.hold = 1; r.k3 = 1; stall_total++;
            bubbles_left--;
        end else if (dep3) begin
            r.hold = 1; r.k3 = 1; stall_total++;
            bubbles_left = 1;
        end else if (dep4) begin
            r.hold = 1; r.k3 = 1; stall_total++;
        end else if (s.hlt) begin
            r.hold = 1; r.k2 = 1;
            drain_left = DRAIN;
        end
        return r;
    endfunction

    task automatic step(input stim_t s);
        @(posedge clock);
        #1;
        reset = s.rst; a_addr = s.a; b_addr = s.b; w3 = s.w3; w4 = s.w4;
        use_a = s.ua; use_b = s.ub; ld3 = s.l3; ld4 = s.l4;
        br = s.br; hlt = s.hlt; res = s.res;
        exp_q.push_back(model(s));
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Monitor: compares the DUT's outputs against the queued expectation each cycle.
    initial begin
        resp_t got, e;
        forever begin
            @(negedge clock);
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{hold_p1, kill_p2, kill_p3, pc_redirect, halted, stall_cycles};
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL outputs cycle %0d: got hold=%b k2=%b k3=%b redir=%b halted=%b cnt=%0d, want hold=%b k2=%b k3=%b redir=%b halted=%b cnt=%0d",
                             cyc, got.hold, got.k2, got.k3, got.redir, got.halted, got.cnt,
                             e.hold, e.k2, e.k3, e.redir, e.halted, e.cnt);
                end
            end
        end
    end

    initial begin
        stim_t s;
        reset = 1'b1; a_addr = 0; b_addr = 0; w3 = 0; w4 = 0;
        use_a = 0; use_b = 0; ld3 = 0; ld4 = 0; br = 0; hlt = 0; res = 0;

        s = idle(); s.rst = 1;
        repeat (2) step(s);
        step(idle());

        // Load in p3, consumer reads it via A: two bubbles.
        s = idle(); s.l3 = 1; s.w3 = 3; s.a = 3; s.ua = 1;
        step(s);
        s = idle(); s.l4 = 1; s.w4 = 3; s.a = 3; s.ua = 1;
        step(s);
        s = idle(); s.a = 3; s.ua = 1;
        step(s);
        step(idle());

        // Load in p4 via B: one bubble; then B unused: none.
        s = idle(); s.l4 = 1; s.w4 = 5; s.b = 5; s.ub = 1;
        step(s);
        step(idle());
        s = idle(); s.l4 = 1; s.w4 = 5; s.b = 5;
        step(s);

        // Branch in the same cycle as a p3 load-use: branch wins, no stall.
        s = idle(); s.l3 = 1; s.w3 = 3; s.a = 3; s.ua = 1; s.br = 1;
        step(s);
        step(idle());

        // Halt, drain, halted, ignored resume-less cycles, then resume.
        s = idle(); s.hlt = 1;
        step(s);
        s = idle(); s.br = 1; s.hlt = 1;
        repeat (5) step(s);
        step(idle());
        s = idle(); s.res = 1;
        step(s);
        step(idle());
        step(s);                         // resume outside HALTED: no effect

        // Halt and p3 hazard together: stall first, halt accepted later.
        s = idle(); s.hlt = 1; s.l3 = 1; s.w3 = 1; s.b = 1; s.ub = 1;
        step(s);
        s = idle(); s.hlt = 1;
        repeat (2) step(s);
        repeat (5) step(idle());
        s = idle(); s.res = 1;
        step(s);

        // Reset during LOAD_STALL and during DRAIN.
        s = idle(); s.l3 = 1; s.w3 = 7; s.a = 7; s.ua = 1;
        step(s);
        s = idle(); s.rst = 1;
        step(s);
        step(idle());
        s = idle(); s.hlt = 1;
        step(s);
        step(idle());
        s = idle(); s.rst = 1;
        step(s);
        repeat (2) step(idle());

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s     = idle();
            s.rst = ($urandom_range(0, 99) == 0);
            s.a   = 3'($urandom_range(0, 3));
            s.b   = 3'($urandom_range(0, 3));
            s.w3  = 3'($urandom_range(0, 3));
            s.w4  = 3'($urandom_range(0, 3));
            s.ua  = 1'($urandom_range(0, 1));
            s.ub  = 1'($urandom_range(0, 1));
            s.l3  = ($urandom_range(0, 2) == 0);
            s.l4  = ($urandom_range(0, 2) == 0);
            s.br  = ($urandom_range(0, 7) == 0);
            s.hlt = ($urandom_range(0, 9) == 0);
            s.res = ($urandom_range(0, 3) == 0);
            step(s);
        end

        // Saturation: continuous p4 load-use stalls past 0xFFFF.
        s = idle(); s.rst = 1;
        step(s);
        s = idle(); s.l4 = 1; s.w4 = 2; s.a = 2; s.ua = 1;
        for (int i = 0; i < 65540; i++) step(s);
        step(idle());

        @(negedge clock);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_queue: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
